// File: rtl/ula_mdu_control_pkg.sv
// Shared ULA select codes, funct7 constants and MDU state encoding for the
// EX-stage ALU control and the iterative multiply/divide unit.
package ula_mdu_control_pkg;

    localparam logic [3:0] ULA_NONE = 4'b0000;
    localparam logic [3:0] ULA_ADD  = 4'b0001;
    localparam logic [3:0] ULA_SUB  = 4'b0010;
    localparam logic [3:0] ULA_SLL  = 4'b0011;
    localparam logic [3:0] ULA_SLT  = 4'b0100;
    localparam logic [3:0] ULA_SLTU = 4'b0101;
    localparam logic [3:0] ULA_SRL  = 4'b0110;
    localparam logic [3:0] ULA_SRA  = 4'b0111;
    localparam logic [3:0] ULA_XOR  = 4'b1000;
    localparam logic [3:0] ULA_OR   = 4'b1001;
    localparam logic [3:0] ULA_AND  = 4'b1010;
    localparam logic [3:0] ULA_MDU  = 4'b1011;

    localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_MUL  = 2'b01,
        MDU_DIV  = 2'b10,
        MDU_DONE = 2'b11
    } mdu_state_e;

    // Latched per-op control: funct3 plus the final result-negate flag.
    typedef struct packed {
        logic [2:0] f3;
        logic       neg;
    } md_op_t;

    // rs1 is signed for MUL/MULH/MULHSU and for DIV/REM.
    function automatic logic a_is_signed(input logic [2:0] f3);
        return f3[2] ? ~f3[0] : (f3[1:0] != 2'b11);
    endfunction

    // rs2 is signed for MUL/MULH and for DIV/REM.
    function automatic logic b_is_signed(input logic [2:0] f3);
        return f3[2] ? ~f3[0] : ~f3[1];
    endfunction

endpackage

// File: rtl/ula_decode.sv
// Combinational ALU-control decoder: {funct7,funct3} and ula_op to the
// 4-bit ULA select code.
module ula_decode
    import ula_mdu_control_pkg::*;
#(
    parameter bit EN_M = 1'b1
) (
    input  logic [9:0] inst,
    input  logic [1:0] ula_op,
    output logic [3:0] ula_select
);

    logic [6:0] f7;
    logic [2:0] f3;
    logic       is_r;

    assign f7   = inst[9:3];
    assign f3   = inst[2:0];
    assign is_r = (ula_op == 2'b10);

    always_comb begin
        ula_select = ULA_NONE;
        case (ula_op)
            2'b00: ula_select = ULA_ADD;
            2'b01: ula_select = ULA_SUB;
            default: begin
                // With M absent an R-type MULDIV funct7 must not alias an ALU op.
                if (is_r && f7 == FUNCT7_MULDIV) begin
                    ula_select = EN_M ? ULA_MDU : ULA_NONE;
                end else begin
                    case (f3)
                        3'b000: ula_select = (is_r && f7 == FUNCT7_ALT) ? ULA_SUB : ULA_ADD;
                        3'b001: ula_select = ULA_SLL;
                        3'b010: ula_select = ULA_SLT;
                        3'b011: ula_select = ULA_SLTU;
                        3'b100: ula_select = ULA_XOR;
                        3'b101: begin
                            if (f7 == FUNCT7_BASE)     ula_select = ULA_SRL;
                            else if (f7 == FUNCT7_ALT) ula_select = ULA_SRA;
                            else                       ula_select = ULA_NONE;
                        end
                        3'b110: ula_select = ULA_OR;
                        default: ula_select = ULA_AND;
                    endcase
                end
            end
        endcase
    end

endmodule

// File: rtl/ula_mdu_control.sv
// EX-stage ALU control plus an iterative M-extension multiply/divide unit
// (one shift-add / restoring step per cycle) with start/done and stall.
module ula_mdu_control
    import ula_mdu_control_pkg::*;
#(
    parameter int XLEN = 32,
    parameter bit EN_M = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [9:0]      inst,
    input  logic [1:0]      ula_op,
    input  logic            start,
    input  logic            flush,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [3:0]      ula_select,
    output logic            stall,
    output logic            md_busy,
    output logic            md_done,
    output logic [XLEN-1:0] md_result
);

    localparam int CW = $clog2(XLEN) + 1;

    mdu_state_e          state_q, state_d;
    md_op_t              op_q, op_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [XLEN-1:0]     res_q, res_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    ula_decode #(.EN_M(EN_M)) u_decode (
        .inst       (inst),
        .ula_op     (ula_op),
        .ula_select (ula_select)
    );

    // Operand preparation for the op being offered in IDLE.
    logic [2:0]      f3_in;
    logic            mdu_req, a_neg, b_neg, div0, ovf;
    logic [XLEN-1:0] a_mag, b_mag, special_res;

    assign f3_in   = inst[2:0];
    assign mdu_req = EN_M && start && (ula_select == ULA_MDU);
    assign a_neg   = a_is_signed(f3_in) & op_a[XLEN-1];
    assign b_neg   = b_is_signed(f3_in) & op_b[XLEN-1];
    assign a_mag   = a_neg ? -op_a : op_a;
    assign b_mag   = b_neg ? -op_b : op_b;
    assign div0    = (op_b == '0);
    assign ovf     = ~f3_in[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&op_b);

    always_comb begin
        special_res = '0;
        if (div0)     special_res = f3_in[1] ? op_a : '1;
        else if (ovf) special_res = f3_in[1] ? '0 : op_a;
    end

    // One iteration of each algorithm; acc holds {hi, lo} for both.
    logic [XLEN:0]       mul_sum, div_sh, div_diff;
    logic [2*XLEN-1:0]   mul_next, div_next, mul_full;
    logic [XLEN-1:0]     mul_res, div_val, div_res;
    logic                last_step;

    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_q};
    assign mul_next = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};

    assign div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff = div_sh - {1'b0, b_q};
    assign div_next = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    assign mul_full = op_q.neg ? -mul_next : mul_next;
    assign mul_res  = (op_q.f3[1:0] == 2'b00) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
    assign div_val  = op_q.f3[1] ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
    assign div_res  = op_q.neg ? -div_val : div_val;

    assign last_step = (cnt_q == CW'(XLEN - 1));

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        case (state_q)
            MDU_IDLE: begin
                if (mdu_req) begin
                    op_d.f3 = f3_in;
                    // Remainder follows the dividend sign; everything else the product/quotient sign.
                    op_d.neg = (f3_in[2] && f3_in[1]) ? a_neg : (a_neg ^ b_neg);
                    acc_d    = {{XLEN{1'b0}}, a_mag};
                    b_d      = b_mag;
                    cnt_d    = '0;
                    if (f3_in[2] && (div0 || ovf)) begin
                        res_d   = special_res;
                        state_d = MDU_DONE;
                    end else begin
                        state_d = f3_in[2] ? MDU_DIV : MDU_MUL;
                    end
                end
            end
            MDU_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + CW'(1);
                if (last_step) begin
                    res_d   = mul_res;
                    state_d = MDU_DONE;
                end
            end
            MDU_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + CW'(1);
                if (last_step) begin
                    res_d   = div_res;
                    state_d = MDU_DONE;
                end
            end
            default: state_d = MDU_IDLE;
        endcase
        // Flush abandons the op without touching the last delivered result.
        if (flush) begin
            state_d = MDU_IDLE;
            res_d   = res_q;
        end
        if (!EN_M) begin
            state_d = MDU_IDLE;
            res_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MDU_IDLE;
            op_q    <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall     = (state_q == MDU_IDLE && mdu_req) || (state_q == MDU_MUL) || (state_q == MDU_DIV);
    assign md_busy   = (state_q != MDU_IDLE);
    assign md_done   = (state_q == MDU_DONE);
    assign md_result = res_q;

endmodule

// File: tb/tb_ula_mdu_control.sv
// Randomized self-checking bench for ula_mdu_control (XLEN=32) against an
// arithmetic reference model of the decode table and the M-extension ops.
module tb_ula_mdu_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  inst;
    logic [1:0]  ula_op;
    logic        start, flush;
    logic [31:0] op_a, op_b;
    logic [3:0]  ula_select;
    logic        stall, md_busy, md_done;
    logic [31:0] md_result;

    int n_chk = 0;
    int n_fail = 0;

    ula_mdu_control #(.XLEN(32), .EN_M(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inst       (inst),
        .ula_op     (ula_op),
        .start      (start),
        .flush      (flush),
        .op_a       (op_a),
        .op_b       (op_b),
        .ula_select (ula_select),
        .stall      (stall),
        .md_busy    (md_busy),
        .md_done    (md_done),
        .md_result  (md_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] dec_ref(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3);
        if (op == 2'b00) return 4'd1;
        if (op == 2'b01) return 4'd2;
        if (op == 2'b10 && f7 == 7'h01) return 4'd11;
        case (f3)
            3'd0: return (op == 2'b10 && f7 == 7'h20) ? 4'd2 : 4'd1;
            3'd1: return 4'd3;
            3'd2: return 4'd4;
            3'd3: return 4'd5;
            3'd4: return 4'd8;
            3'd5: return (f7 == 7'h00) ? 4'd6 : (f7 == 7'h20) ? 4'd7 : 4'd0;
            3'd6: return 4'd9;
            default: return 4'd10;
        endcase
    endfunction

    function automatic logic [31:0] md_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    // Issue one MDU op; start stays high for 'hold' cycles after acceptance
    // with scrambled operands, which the busy unit must ignore.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input int hold);
        int cyc, stl, exp_lat;
        logic [31:0] exp_r;
        exp_r   = md_ref(f3, a, b);
        exp_lat = (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 33;
        inst = {7'h01, f3}; ula_op = 2'b10; op_a = a; op_b = b; start = 1'b1;
        #1;
        chk("stall_req", stall, 1);
        stl = 1;
        @(posedge clk); #1;
        start = (hold > 0);
        cyc = 1;
        while (!md_done && cyc < 100) begin
            if (stall) stl++;
            if (cyc >= hold) start = 1'b0;
            else begin
                op_a = $urandom; op_b = $urandom; inst = {7'h01, 3'($urandom_range(0, 7))};
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk($sformatf("lat f3=%0d", f3), cyc, exp_lat);
        chk($sformatf("stall_cnt f3=%0d", f3), stl, exp_lat);
        chk($sformatf("result f3=%0d a=%h b=%h", f3, a, b), md_result, exp_r);
        @(posedge clk); #1;
        chk("done_pulse", md_done, 0);
        chk("busy_after", md_busy, 0);
        chk("result_held", md_result, exp_r);
    endtask

    initial begin
        logic [6:0] f7s [4];
        logic [31:0] prev, ra, rb;
        logic [2:0] rf3;
        int seen_done;
        f7s[0] = 7'h00; f7s[1] = 7'h20; f7s[2] = 7'h01; f7s[3] = 7'h7F;
        rst_n = 1'b0; inst = '0; ula_op = '0; start = 1'b0; flush = 1'b0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", md_busy, 0);
        chk("rst_done", md_done, 0);
        chk("rst_result", md_result, 0);
        chk("rst_stall", stall, 0);
        rst_n = 1'b1;

        // Decode sweep.
        for (int op = 0; op < 4; op++)
            for (int f3 = 0; f3 < 8; f3++)
                for (int k = 0; k < 4; k++) begin
                    ula_op = 2'(op); inst = {f7s[k], 3'(f3)};
                    #1;
                    chk($sformatf("dec op=%0d f3=%0d f7=%h", op, f3, f7s[k]), ula_select,
                        dec_ref(2'(op), f7s[k], 3'(f3)));
                end
        for (int i = 0; i < 40; i++) begin
            ula_op = 2'($urandom_range(0, 3)); inst = 10'($urandom);
            #1;
            chk("dec_rand", ula_select, dec_ref(ula_op, inst[9:3], inst[2:0]));
        end

        // Non-MDU start in IDLE.
        @(posedge clk); #1;
        ula_op = 2'b10; inst = {7'h00, 3'b000}; start = 1'b1;
        #1;
        chk("nonmdu_stall", stall, 0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("nonmdu_busy", md_busy, 0);

        // Directed cases.
        do_op(3'd1, 32'hFFFF_FFFE, 32'd3, 0);
        do_op(3'd0, 32'hFFFF_FFFE, 32'd3, 0);
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op(3'd4, 32'd7, 32'hFFFF_FFFE, 0);
        do_op(3'd6, 32'd7, 32'hFFFF_FFFE, 0);
        do_op(3'd5, 32'd7, 32'd2, 0);
        do_op(3'd5, 32'd5, 32'd0, 0);
        do_op(3'd7, 32'd5, 32'd0, 0);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(3'd2, 32'h8000_0001, 32'hFFFF_FFFF, 12);

        // Randomized ops with corner-value injection.
        for (int i = 0; i < 30; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra = $urandom; rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            do_op(rf3, ra, rb, int'($urandom_range(0, 3)));
        end

        // Flush mid-MUL.
        prev = md_result;
        inst = {7'h01, 3'b011}; ula_op = 2'b10; op_a = $urandom; op_b = $urandom; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", md_busy, 0);
        chk("flush_stall", stall, 0);
        chk("flush_result", md_result, prev);
        seen_done = 0;
        repeat (3) begin
            if (md_done) seen_done++;
            @(posedge clk); #1;
        end
        chk("flush_no_done", seen_done, 0);
        do_op(3'd1, 32'h1234_5678, 32'h8765_4321, 0);

        // Async reset mid-DIV.
        do_op(3'd5, 32'd100, 32'd7, 0);
        inst = {7'h01, 3'b100}; ula_op = 2'b10; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", md_busy, 0);
        chk("arst_done", md_done, 0);
        chk("arst_result", md_result, 0);
        chk("arst_stall", stall, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_op(3'd4, 32'hFFFF_FF9C, 32'd7, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
